inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Upstream neighbour of the CPU decode/execute state machine.
- Streams 8 instruction bytes from the byte-wide synchronous program BRAM (1-cycle read latency) and assembles them into one 64-bit instruction word.
- Hands the word to the core over a valid/ready handshake.
- Accepts PC redirects from execute (JMP/JZ/JNZ/JL/JGE) and discards any wrong-path fetch in progress.

Parameters:
- ADDR_W, 16, BRAM byte-address width.
- INST_BYTES, 8, bytes per instruction.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  permits a new fetch to start. A fetch already in progress completes regardless.
- mem_addr  out  ADDR_W  BRAM byte address (registered).
- mem_rdata  in  8  BRAM read data, valid one cycle after mem_addr.
- inst_valid  out  1  inst_data/inst_pc hold a complete instruction.
- inst_ready  in  1  consumer accepts; transfer occurs on valid&ready&!redirect_valid.
- inst_data  out  64  {opcode[63:56], mode[55:48], reg0[47:40], reg1[39:32], raw2[31:0]}.
- inst_pc  out  32  byte address of the instruction's first byte.
- redirect_valid  in  1  jump taken; restart fetch at redirect_pc.
- redirect_pc  in  32  new PC.

Behaviour:
- Reset (Rst high at posedge, any state):
  - pc <= RESET_PC; state <= IDLE.
  - inst_valid <= 0; inst_data <= 0; inst_pc <= 0; mem_addr <= RESET_PC[ADDR_W-1:0].
  - Byte counters cleared; any fetch in progress is discarded.
- States: IDLE, ISSUE, HOLD.
- IDLE:
  - If fetch_en, go to ISSUE, latch start_pc = pc and drive mem_addr = pc.
  - Otherwise remain in IDLE.
- ISSUE:
  - mem_addr advances by 1 per cycle for INST_BYTES addresses.
  - Bytes are captured one cycle after their address is presented.
  - Byte order: bytes at offsets 0..3 go to opcode, mode, reg0, reg1. Bytes at offsets 4..7 go to raw2 little-endian: offset 4 -> raw2[7:0] through offset 7 -> raw2[31:24].
  - The cycle after the 8th byte is captured: inst_valid <= 1, inst_pc <= start_pc, pc <= start_pc + 8 (32-bit, wraps mod 2^32), state <= HOLD.
- Latency: with the first address presented in cycle T, inst_valid is high in cycle T+9.
- HOLD:
  - inst_data and inst_pc are stable; mem_addr is frozen.
  - On transfer: inst_valid <= 0. If fetch_en, go directly to ISSUE at pc; otherwise go to IDLE.
  - No prefetch while holding.
- Redirect (any state, priority over everything except Rst):
  - pc <= redirect_pc; inst_valid <= 0; byte counters cleared.
  - Any in-flight BRAM byte is dropped.
  - State <= ISSUE if fetch_en, else IDLE. mem_addr <= redirect_pc[ADDR_W-1:0] next cycle.
  - A valid&ready in the same cycle is void; the consumer must not retire that word.
- Address wrap: mem_addr = pc[ADDR_W-1:0] + offset modulo 2^ADDR_W. An instruction straddling 0xFFFF continues at 0x0000. The upper bits of pc still increment.
- fetch_en falling mid-ISSUE: the current instruction completes; no new fetch starts after its handshake.
- Fetch is consumer-paced: throughput is at most one instruction per 9 cycles plus handshake wait.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants (I_NOP..I_DIE, I_DIE = 8'hFF).
  - Register indices R_SP = 11, R_BA = 12, R_FL = 13.
  - Flag bit positions.
  - INST_BYTES and the inst_data field slice positions.
  - The fetch state encoding.
- No sub-module is required. The byte assembler is inline: a 3-bit capture index plus a one-cycle delayed "capture pending" flag tracking BRAM latency.

Test Plan:
- Reset, fetch_en=1, ready=1; BRAM[0..7] = 01 00 02 03 78 56 34 12 -> inst_valid at cycle 9 after first address; inst_data = 64'h0100_0203_1234_5678; inst_pc = 0. Second fetch starts at mem_addr 8.
- Backpressure: hold inst_ready=0 for 5 cycles after inst_valid -> inst_data/inst_pc/mem_addr unchanged throughout. After the handshake, next inst_pc = 8 and no byte is skipped or duplicated.
- Redirect mid-fetch: assert redirect_valid with redirect_pc = 32'h40 while capturing byte 3 -> stale bytes discarded; next mem_addr = 16'h0040; delivered inst_pc = 32'h40 with BRAM[0x40..0x47] contents.
- Wrap: redirect to 32'h0000_FFFC -> mem_addr sequence FFFC, FFFD, FFFE, FFFF, 0000, 0001, 0002, 0003; inst_pc = 32'hFFFC; next fetch pc = 32'h0001_0004 with mem_addr 16'h0004.
- Reset mid-fetch at byte 5 -> next cycle inst_valid = 0 and mem_addr = 0; the following instruction is assembled fresh from address 0 with no leftover bytes.
- fetch_en = 0 from reset -> stays IDLE and mem_addr stays 0. Raising fetch_en starts the fetch. Redirect with valid&ready in the same cycle -> no transfer counted and inst_valid low next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, register indices, flag bits, instruction
// word layout and the fetch state encoding.
package cpu_pkg;

  localparam int FETCH_BYTES = 8;

  localparam logic [7:0] I_NOP   = 8'h00;
  localparam logic [7:0] I_LOAD  = 8'h01;
  localparam logic [7:0] I_STORE = 8'h02;
  localparam logic [7:0] I_MOV   = 8'h03;
  localparam logic [7:0] I_ADD   = 8'h04;
  localparam logic [7:0] I_SUB   = 8'h05;
  localparam logic [7:0] I_CMP   = 8'h06;
  localparam logic [7:0] I_JMP   = 8'h07;
  localparam logic [7:0] I_JZ    = 8'h08;
  localparam logic [7:0] I_JNZ   = 8'h09;
  localparam logic [7:0] I_JL    = 8'h0A;
  localparam logic [7:0] I_JGE   = 8'h0B;
  localparam logic [7:0] I_DIE   = 8'hFF;

  localparam int R_SP = 11;
  localparam int R_BA = 12;
  localparam int R_FL = 13;

  localparam int FL_Z = 0;
  localparam int FL_N = 1;
  localparam int FL_C = 2;

  localparam int OPC_LSB  = 56;
  localparam int MODE_LSB = 48;
  localparam int REG0_LSB = 40;
  localparam int REG1_LSB = 32;
  localparam int RAW2_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // Offsets 0..3 fill the byte fields top-down; 4..7 fill raw2 little-endian.
  function automatic int byte_lsb(input int idx);
    return (idx < 4) ? (OPC_LSB - 8 * idx) : (RAW2_LSB + 8 * (idx - 4));
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: streams INST_BYTES bytes from a 1-cycle BRAM into one
// 64-bit word, holds it until the core accepts, and restarts on redirects.
module inst_fetch import cpu_pkg::*; #(
  parameter int          ADDR_W     = 16,
  parameter int          INST_BYTES = FETCH_BYTES,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [63:0]       inst_data,
  output logic [31:0]       inst_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc
);

  localparam int IW = $clog2(INST_BYTES);
  localparam logic [IW-1:0] LAST = IW'(INST_BYTES - 1);

  fetch_state_t  state;
  logic [31:0]   pc;
  logic [31:0]   start_pc;
  logic [IW-1:0] addr_idx;
  logic [IW-1:0] cap_idx;
  logic          addr_done;
  logic          cap_pend;
  logic          xfer;

  assign xfer = inst_valid && inst_ready && !redirect_valid;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      start_pc   <= RESET_PC;
      mem_addr   <= RESET_PC[ADDR_W-1:0];
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
      addr_idx   <= '0;
      cap_idx    <= '0;
      addr_done  <= 1'b0;
      cap_pend   <= 1'b0;
    end else if (redirect_valid) begin
      // Wrong-path bytes, including the one still in the BRAM pipe, are dropped.
      state      <= fetch_en ? ISSUE : IDLE;
      pc         <= redirect_pc;
      start_pc   <= redirect_pc;
      mem_addr   <= redirect_pc[ADDR_W-1:0];
      inst_valid <= 1'b0;
      addr_idx   <= '0;
      cap_idx    <= '0;
      addr_done  <= 1'b0;
      cap_pend   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en) begin
            state     <= ISSUE;
            start_pc  <= pc;
            mem_addr  <= pc[ADDR_W-1:0];
            addr_idx  <= '0;
            cap_idx   <= '0;
            addr_done <= 1'b0;
            cap_pend  <= 1'b0;
          end
        end
        ISSUE: begin
          // cap_pend marks that the byte on mem_rdata belongs to this fetch.
          cap_pend <= !addr_done;
          if (!addr_done) begin
            if (addr_idx == LAST) begin
              addr_done <= 1'b1;
            end else begin
              addr_idx <= addr_idx + 1'b1;
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
          if (cap_pend) begin
            inst_data[byte_lsb(int'(cap_idx)) +: 8] <= mem_rdata;
            if (cap_idx == LAST) begin
              inst_valid <= 1'b1;
              inst_pc    <= start_pc;
              pc         <= start_pc + 32'(INST_BYTES);
              state      <= HOLD;
            end else begin
              cap_idx <= cap_idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (xfer) begin
            inst_valid <= 1'b0;
            addr_idx   <= '0;
            cap_idx    <= '0;
            addr_done  <= 1'b0;
            cap_pend   <= 1'b0;
            if (fetch_en) begin
              state    <= ISSUE;
              start_pc <= pc;
              mem_addr <= pc[ADDR_W-1:0];
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: vector table, directed corner sequences
// and a randomized run against an in-order instruction-stream model.
module tb_inst_fetch;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        fetch_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [63:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem [0:65535];

  typedef struct {
    logic [31:0] pc;
    logic [63:0] bytes;
    logic [63:0] exp_data;
  } vec_t;

  vec_t tbl [4];

  always #5 Clk = ~Clk;

  always @(posedge Clk) mem_rdata <= mem[mem_addr];

  inst_fetch #(.ADDR_W(16), .INST_BYTES(8), .RESET_PC(32'h0)) dut (
    .Clk(Clk), .Rst(Rst), .fetch_en(fetch_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Instruction word straight from the byte layout rules.
  function automatic logic [63:0] ref_word(input logic [31:0] pc);
    logic [15:0] a;
    a = pc[15:0];
    return {mem[a], mem[a + 16'd1], mem[a + 16'd2], mem[a + 16'd3],
            mem[a + 16'd7], mem[a + 16'd6], mem[a + 16'd5], mem[a + 16'd4]};
  endfunction

  task automatic do_reset();
    Rst = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick();
    Rst = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    while (!inst_valid && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int          n;
    int          nx;
    logic [31:0] exp_pc;
    logic        saw_valid;
    logic [15:0] a;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    tbl[0] = '{32'h0000_0000, 64'h0100_0203_7856_3412, 64'h0100_0203_1234_5678};
    tbl[1] = '{32'h0000_0040, 64'h0A01_0506_EFBE_ADDE, 64'h0A01_0506_DEAD_BEEF};
    tbl[2] = '{32'h0000_FFFC, 64'h1122_3344_0100_0203, 64'h1122_3344_0302_0001};
    tbl[3] = '{32'h0001_2345, 64'hFF02_0B0C_0000_0080, 64'hFF02_0B0C_8000_0000};
    for (int v = 0; v < 4; v++)
      for (int k = 0; k < 8; k++) begin
        a = tbl[v].pc[15:0] + 16'(k);
        mem[a] = tbl[v].bytes[63 - 8 * k -: 8];
      end

    do_reset();
    chk("reset_valid", 64'(inst_valid), 64'd0);
    chk("reset_data", inst_data, 64'd0);
    chk("reset_pc", 64'(inst_pc), 64'd0);
    chk("reset_addr", 64'(mem_addr), 64'd0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      redirect_valid = 1'b1; redirect_pc = tbl[v].pc; fetch_en = 1'b1;
      tick();
      redirect_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
        chk("vec_addr_seq", 64'(mem_addr), 64'(16'(tbl[v].pc[15:0] + 16'(k))));
        tick();
      end
      chk("vec_valid_t8", 64'(inst_valid), 64'd0);
      tick();
      chk("vec_valid_t9", 64'(inst_valid), 64'd1);
      for (int h = 0; h < 5; h++) begin
        chk("vec_hold_data", inst_data, tbl[v].exp_data);
        chk("vec_hold_pc", 64'(inst_pc), 64'(tbl[v].pc));
        chk("vec_hold_addr", 64'(mem_addr), 64'(16'(tbl[v].pc[15:0] + 16'd7)));
        tick();
      end
      chk("vec_hold_valid", 64'(inst_valid), 64'd1);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk("vec_xfer_valid", 64'(inst_valid), 64'd0);
      chk("vec_next_addr", 64'(mem_addr), 64'(16'(tbl[v].pc[15:0] + 16'd8)));
      wait_valid(20, n);
      chk("vec_next_lat", 64'(n), 64'd9);
      chk("vec_next_pc", 64'(inst_pc), 64'(tbl[v].pc + 32'd8));
      chk("vec_next_data", inst_data, ref_word(tbl[v].pc + 32'd8));
    end

    // fetch_en low from reset: nothing moves until it rises.
    do_reset();
    saw_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (inst_valid || mem_addr != 16'd0) saw_valid = 1'b1;
      tick();
    end
    chk("idle_quiet", 64'(saw_valid), 64'd0);
    fetch_en = 1'b1;
    wait_valid(30, n);
    chk("idle_start_lat", 64'(n), 64'd10);
    chk("idle_start_pc", 64'(inst_pc), 64'd0);
    chk("idle_start_data", inst_data, 64'h0100_0203_1234_5678);

    // Redirect coinciding with valid&ready voids the transfer.
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    chk("void_valid", 64'(inst_valid), 64'd0);
    chk("void_addr", 64'(mem_addr), 64'h40);
    wait_valid(20, n);
    chk("void_lat", 64'(n), 64'd9);
    chk("void_pc", 64'(inst_pc), 64'h40);

    // Redirect while byte 3 is being captured.
    do_reset();
    fetch_en = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("midredir_addr", 64'(mem_addr), 64'h40);
    chk("midredir_valid", 64'(inst_valid), 64'd0);
    wait_valid(20, n);
    chk("midredir_lat", 64'(n), 64'd9);
    chk("midredir_pc", 64'(inst_pc), 64'h40);
    chk("midredir_data", inst_data, 64'h0A01_0506_DEAD_BEEF);

    // Reset while byte 5 is being captured.
    do_reset();
    fetch_en = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("midrst_valid", 64'(inst_valid), 64'd0);
    chk("midrst_addr", 64'(mem_addr), 64'd0);
    chk("midrst_data", inst_data, 64'd0);
    wait_valid(30, n);
    chk("midrst_lat", 64'(n), 64'd10);
    chk("midrst_fresh", inst_data, 64'h0100_0203_1234_5678);

    // Randomized run: delivered words must follow the redirect-aware pc stream.
    do_reset();
    exp_pc = 32'h0;
    nx = 0;
    for (int c = 0; c < 5000; c++) begin
      fetch_en       = ($urandom_range(0, 9) < 8);
      inst_ready     = $urandom_range(0, 1) == 1;
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = $urandom();
      if (inst_valid && inst_ready && !redirect_valid) begin
        chk("rand_pc", 64'(inst_pc), 64'(exp_pc));
        chk("rand_data", inst_data, ref_word(exp_pc));
        exp_pc = exp_pc + 32'd8;
        nx++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      tick();
    end
    chk("rand_progress", 64'(nx > 50), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
